// File: rtl/ddr3_read_if.sv
// Avalon-MM burst-read port and byte-serial pixel port of the frame read-back engine.
// master = the engine, slave = DDR3 controller / pixel consumer side.
interface ddr3_read_if;
  logic         avl_waitrequest;
  logic [31:0]  avl_addr;
  logic         avl_read_req;
  logic [9:0]   avl_size;
  logic [15:0]  avl_be;
  logic         avl_rdata_valid;
  logic [127:0] avl_rdata;
  logic [7:0]   pix_data;
  logic         pix_valid;
  logic         pix_ready;
  logic         pix_sof;
  logic         pix_eof;

  modport master (
    input  avl_waitrequest, avl_rdata_valid, avl_rdata, pix_ready,
    output avl_addr, avl_read_req, avl_size, avl_be,
           pix_data, pix_valid, pix_sof, pix_eof
  );

  modport slave (
    output avl_waitrequest, avl_rdata_valid, avl_rdata, pix_ready,
    input  avl_addr, avl_read_req, avl_size, avl_be,
           pix_data, pix_valid, pix_sof, pix_eof
  );
endinterface

// File: rtl/ddr3_read.sv
// Frame read-back engine: burst-reads a stored 8-bit frame from DDR3 and replays it
// as a little-endian byte stream with valid/ready flow control.
//  state | meaning
//  IDLE  | waiting for start
//  CHECK | size next burst, wait until FIFO credit covers it
//  REQ   | burst request on Avalon, held stable while stalled
//  DRAIN | all bursts issued, waiting for the last pixel
//  DONE  | one-cycle done pulse
module ddr3_read #(
  parameter int BURST_LEN  = 32,
  parameter int FIFO_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] buffer_base,
  input  logic [31:0] img_size,
  output logic        busy,
  output logic        done,
  ddr3_read_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]   addr, pix_left;
  logic [27:0]   words_left;
  logic [CW-1:0] fifo_count, outstanding;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [127:0]  mem [FIFO_DEPTH];
  logic [127:0]  word;
  logic [3:0]    rem;
  logic [7:0]    data_r;
  logic          valid_r, first;
  logic [9:0]    blen;
  logic [31:0]   free;
  logic          burst_ok, push, pop, accept, advance;

  assign blen     = (words_left < 28'(BURST_LEN)) ? words_left[9:0] : 10'(BURST_LEN);
  // Credit counts words already requested but not yet landed, so the FIFO cannot overflow.
  assign free     = 32'(FIFO_DEPTH) - 32'(fifo_count) - 32'(outstanding);
  assign burst_ok = (state == REQ) && !bus.avl_waitrequest;
  assign push     = bus.avl_rdata_valid && (state != IDLE);
  assign accept   = valid_r && bus.pix_ready;
  assign advance  = !valid_r || accept;
  assign pop      = advance && (rem == 4'd0) && (fifo_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = CHECK;
      CHECK: if (words_left == '0) state_nxt = (pix_left == '0) ? DONE : DRAIN;
             else if (free >= 32'(blen)) state_nxt = REQ;
      REQ:   if (!bus.avl_waitrequest) state_nxt = CHECK;
      DRAIN: if (pix_left == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    bus.avl_read_req = 1'b0;
    bus.avl_addr     = '0;
    bus.avl_size     = '0;
    unique case (state)
      CHECK, DRAIN: busy = 1'b1;
      REQ: begin
        busy             = 1'b1;
        bus.avl_read_req = 1'b1;
        bus.avl_addr     = addr;
        bus.avl_size     = blen;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign bus.avl_be    = 16'hFFFF;
  assign bus.pix_data  = data_r;
  assign bus.pix_valid = valid_r;
  assign bus.pix_sof   = valid_r && first;
  assign bus.pix_eof   = valid_r && (pix_left == 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      words_left  <= '0;
      pix_left    <= '0;
      outstanding <= '0;
      first       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr       <= buffer_base;
        words_left <= img_size[31:4];
        pix_left   <= img_size;
        first      <= 1'b1;
      end else begin
        if (burst_ok) begin
          addr       <= addr + {18'd0, blen, 4'd0};
          words_left <= words_left - 28'(blen);
        end
        if (accept) begin
          pix_left <= pix_left - 32'd1;
          first    <= 1'b0;
        end
      end
      outstanding <= outstanding + (burst_ok ? CW'(blen) : CW'(0)) - CW'(push);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.avl_rdata;
  end

  // Byte register: word holds the not-yet-presented bytes of the current beat at its low end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word    <= '0;
      rem     <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (advance) begin
      if (rem != 4'd0) begin
        data_r  <= word[7:0];
        word    <= word >> 8;
        rem     <= rem - 4'd1;
        valid_r <= 1'b1;
      end else if (pop) begin
        data_r  <= mem[rd_ptr][7:0];
        word    <= mem[rd_ptr] >> 8;
        rem     <= 4'd15;
        valid_r <= 1'b1;
      end else begin
        valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ddr3_read.sv
// Bench for ddr3_read: random Avalon slave and pixel sink, with a reference model that
// predicts bursts and pixel bytes directly from frame base/size.
module tb_ddr3_read;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] buffer_base = '0;
  logic [31:0] img_size = '0;
  logic        busy, done;

  ddr3_read_if bus();

  ddr3_read #(.BURST_LEN(32), .FIFO_DEPTH(128)) dut (
    .clk(clk), .rst(rst), .start(start), .buffer_base(buffer_base),
    .img_size(img_size), .busy(busy), .done(done), .bus(bus.master)
  );

  always #10 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] fr_base;
  int          fr_size, pix_acc, bursts_acc, done_cnt, req_words;
  int          first_beat_cyc, first_pix_cyc, stall_until;
  int          ready_mode, wait_mode, rvalid_pct, stall_left;
  logic [7:0]  pix0, pixlast;
  logic [31:0] b_addr_q[$];
  int          b_size_q[$];
  logic [31:0] beat_q[$];
  bit          held_v, prev_stall;
  logic [31:0] held_addr, exp_a;
  logic [9:0]  held_size;
  logic [7:0]  prev_data;
  int          exp_s, rem_w;

  function automatic void chk(input string name, input bit ok, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Memory contents seen by the slave: byte at address a.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [127:0] beat(input logic [31:0] a);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[8*i +: 8] = mem_byte(a + 32'(i));
    return b;
  endfunction

  // Avalon slave and pixel sink, driven just after each rising edge.
  initial begin
    bus.avl_waitrequest = 1'b0;
    bus.avl_rdata_valid = 1'b0;
    bus.avl_rdata       = '0;
    bus.pix_ready       = 1'b0;
    stall_left = -1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.avl_read_req) begin
        if (stall_left < 0)
          stall_left = (wait_mode == 2) ? 5 : (wait_mode == 1) ? int'($urandom_range(0, 3)) : 0;
        bus.avl_waitrequest = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else begin
        stall_left = -1;
        bus.avl_waitrequest = 1'b0;
      end
      if (beat_q.size() > 0 && int'($urandom_range(0, 99)) < rvalid_pct) begin
        bus.avl_rdata       = beat(beat_q.pop_front());
        bus.avl_rdata_valid = 1'b1;
      end else begin
        bus.avl_rdata       = {$urandom, $urandom, $urandom, $urandom};
        bus.avl_rdata_valid = 1'b0;
      end
      case (ready_mode)
        0:       bus.pix_ready = 1'b1;
        1:       bus.pix_ready = ($urandom_range(0, 3) != 0);
        default: bus.pix_ready = (cyc >= stall_until);
      endcase
    end
  end

  // Compare process: every cycle, against the frame model.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (bus.avl_read_req) begin
        if (held_v) begin
          chk("req_addr_stable", bus.avl_addr == held_addr, bus.avl_addr, held_addr);
          chk("req_size_stable", bus.avl_size == held_size, bus.avl_size, held_size);
        end
        if (bus.avl_waitrequest) begin
          held_v = 1'b1;
          held_addr = bus.avl_addr;
          held_size = bus.avl_size;
        end else begin
          held_v = 1'b0;
          rem_w = fr_size / 16 - 32 * bursts_acc;
          exp_s = (rem_w < 32) ? rem_w : 32;
          exp_a = fr_base + 32'(bursts_acc * 512);
          chk("burst_addr", bus.avl_addr == exp_a, bus.avl_addr, exp_a);
          chk("burst_size", int'(bus.avl_size) == exp_s, bus.avl_size, exp_s);
          chk("burst_be", bus.avl_be == 16'hFFFF, bus.avl_be, 16'hFFFF);
          bursts_acc++;
          req_words += int'(bus.avl_size);
          b_addr_q.push_back(bus.avl_addr);
          b_size_q.push_back(int'(bus.avl_size));
          for (int i = 0; i < int'(bus.avl_size); i++) beat_q.push_back(bus.avl_addr + 32'(16 * i));
          chk("fifo_credit", (req_words - pix_acc / 16) <= 129, req_words - pix_acc / 16, 129);
        end
      end
      if (bus.avl_rdata_valid && first_beat_cyc < 0) first_beat_cyc = cyc;
      if (bus.pix_valid && first_pix_cyc < 0) first_pix_cyc = cyc;
      if (prev_stall) begin
        chk("pix_valid_hold", bus.pix_valid, bus.pix_valid, 1);
        chk("pix_data_hold", bus.pix_data == prev_data, bus.pix_data, prev_data);
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_data  = bus.pix_data;
      if (bus.pix_valid && bus.pix_ready) begin
        chk("pix_data", bus.pix_data == mem_byte(fr_base + 32'(pix_acc)), bus.pix_data,
            mem_byte(fr_base + 32'(pix_acc)));
        chk("pix_sof", bus.pix_sof == (pix_acc == 0), bus.pix_sof, pix_acc == 0);
        chk("pix_eof", bus.pix_eof == (pix_acc == fr_size - 1), bus.pix_eof, pix_acc == fr_size - 1);
        if (pix_acc == 0) pix0 = bus.pix_data;
        if (pix_acc == fr_size - 1) pixlast = bus.pix_data;
        pix_acc++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy == 1'b0, busy, 0);
    chk({tag, "_done"}, done == 1'b0, done, 0);
    chk({tag, "_read_req"}, bus.avl_read_req == 1'b0, bus.avl_read_req, 0);
    chk({tag, "_addr"}, bus.avl_addr == 32'd0, bus.avl_addr, 0);
    chk({tag, "_size"}, bus.avl_size == 10'd0, bus.avl_size, 0);
    chk({tag, "_pix_valid"}, bus.pix_valid == 1'b0, bus.pix_valid, 0);
    chk({tag, "_sof"}, bus.pix_sof == 1'b0, bus.pix_sof, 0);
    chk({tag, "_eof"}, bus.pix_eof == 1'b0, bus.pix_eof, 0);
    chk({tag, "_be"}, bus.avl_be == 16'hFFFF, bus.avl_be, 16'hFFFF);
  endtask

  // Starts a frame; returns in cycle 1 after start was sampled.
  task automatic start_frame(input logic [31:0] base, input int size, input int rmode,
                             input int wmode, input int pct);
    ready_mode = rmode; wait_mode = wmode; rvalid_pct = pct;
    fr_base = base; fr_size = size;
    pix_acc = 0; bursts_acc = 0; done_cnt = 0; req_words = 0;
    first_beat_cyc = -1; first_pix_cyc = -1;
    b_addr_q.delete(); b_size_q.delete();
    @(posedge clk); #1;
    start = 1'b1; buffer_base = base; img_size = 32'(size);
    stall_until = cyc + 2000;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy == 1'b1, busy, 1);
    chk("no_req_cycle1", bus.avl_read_req == 1'b0, bus.avl_read_req, 0);
  endtask

  task automatic run_frame(input logic [31:0] base, input int size, input int rmode,
                           input int wmode, input int pct);
    int n;
    int exp_bursts;
    start_frame(base, size, rmode, wmode, pct);
    @(posedge clk); #1;
    chk("req_cycle2", bus.avl_read_req == (size > 0), bus.avl_read_req, size > 0);
    chk("done_cycle2", done == (size == 0), done, size == 0);
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_cnt != 0, done_cnt, 1);
    #1;
    chk("busy_low_after_done", busy == 1'b0, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    exp_bursts = (size / 16 + 31) / 32;
    chk("done_once", done_cnt == 1, done_cnt, 1);
    chk("pix_count", pix_acc == size, pix_acc, size);
    chk("burst_count", bursts_acc == exp_bursts, bursts_acc, exp_bursts);
    if (size > 0)
      chk("first_pix_latency", first_pix_cyc - first_beat_cyc == 2, first_pix_cyc - first_beat_cyc, 2);
  endtask

  initial begin
    int n;
    ready_mode = 0; wait_mode = 0; rvalid_pct = 100;
    fr_base = '0; fr_size = 0; pix_acc = 0; bursts_acc = 0; done_cnt = 0; req_words = 0;
    first_beat_cyc = -1; first_pix_cyc = -1; stall_until = 0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Contiguous 1024-byte frame, no stalls.
    run_frame(32'h1000_0000, 1024, 0, 0, 100);
    chk("b0_addr", b_addr_q[0] == 32'h1000_0000, b_addr_q[0], 32'h1000_0000);
    chk("b0_size", b_size_q[0] == 32, b_size_q[0], 32);
    chk("b1_addr", b_addr_q[1] == 32'h1000_0200, b_addr_q[1], 32'h1000_0200);
    chk("b1_size", b_size_q[1] == 32, b_size_q[1], 32);
    chk("pix0_value", pix0 == 8'h10, pix0, 8'h10);
    chk("pixlast_value", pixlast == 8'hEC, pixlast, 8'hEC);

    // 45 words: bursts of 32 then 13.
    run_frame(32'h2000_0000, 720, 1, 1, 70);
    chk("b1_addr_720", b_addr_q[1] == 32'h2000_0200, b_addr_q[1], 32'h2000_0200);
    chk("b1_size_720", b_size_q[1] == 13, b_size_q[1], 13);

    // Five-cycle waitrequest on every request.
    run_frame(32'h0040_0100, 2048, 0, 2, 100);

    // Consumer stalled for 2000 cycles over a 4 KiB frame.
    run_frame(32'h0800_0000, 4096, 2, 0, 100);

    // Empty frame.
    run_frame(32'h1234_5670, 0, 0, 0, 100);

    // Reset mid-frame with beats in flight.
    start_frame(32'h3000_0000, 4096, 1, 1, 30);
    repeat (80) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (beat_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("stale_beats_drained", beat_q.size() == 0, beat_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_stale_busy", busy == 1'b0, busy, 0);
    chk("idle_after_stale_pix", bus.pix_valid == 1'b0, bus.pix_valid, 0);
    run_frame(32'h4000_0000, 1024, 0, 0, 100);

    // Randomized frames.
    for (int k = 0; k < 6; k++)
      run_frame({$urandom} & 32'hFFFF_FFF0, 16 * int'($urandom_range(0, 100)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(20, 100)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
